// File: rtl/tpu_pkg.sv
// Shared widths and element types for the 4x4 weight-stationary systolic array.
// Latency: n/a (package only).
// Backpressure: n/a.
package tpu_pkg;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int PROD_W = 2 * DATA_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [ACC_W-1:0]  acc_t;

endpackage : tpu_pkg

// File: rtl/tpu_pe.sv
// One processing element: stationary weight, forwarded activation, accumulated partial sum.
// Latency: 1 cycle from inputs to registered wt/dat/psum outputs.
// Backpressure: none; load mode shifts the weight and clears dat/psum every edge.
module tpu_pe
    import tpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  control_i,
    input  data_t wt_i,
    input  data_t data_i,
    input  acc_t  psum_i,
    output data_t wt_o,
    output data_t data_o,
    output acc_t  psum_o
);

    data_t wt_q,   wt_d;
    data_t dat_q,  dat_d;
    acc_t  psum_q, psum_d;
    prod_t prod;

    // Unsigned 8x8 product; it is zero-extended into the 24-bit accumulator.
    assign prod = data_i * wt_q;

    // Load mode shifts weights down and flushes the pipeline; compute mode holds weights and MACs.
    always_comb begin
        wt_d   = wt_q;
        dat_d  = dat_q;
        psum_d = psum_q;
        if (control_i) begin
            wt_d   = wt_i;
            dat_d  = '0;
            psum_d = '0;
        end else begin
            dat_d  = data_i;
            psum_d = psum_i + {{(ACC_W-PROD_W){1'b0}}, prod};
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_q   <= '0;
            dat_q  <= '0;
            psum_q <= '0;
        end else begin
            wt_q   <= wt_d;
            dat_q  <= dat_d;
            psum_q <= psum_d;
        end
    end

    assign wt_o   = wt_q;
    assign data_o = dat_q;
    assign psum_o = psum_q;

endmodule : tpu_pe

// File: rtl/tpu_mmu.sv
// 4x4 weight-stationary systolic matrix unit; driver supplies the input skew.
// Latency: vector k's column-c result is on pe3c_out right after edge k+3+c.
// Backpressure: none; one result per column per cycle, control=1 flushes in-flight sums.
module tpu_mmu
    import tpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  control,
    input  logic [N*DATA_W-1:0]   wt_arr,
    input  logic [N*DATA_W-1:0]   data_arr,
    output logic [ACC_W-1:0]      pe30_out,
    output logic [ACC_W-1:0]      pe31_out,
    output logic [ACC_W-1:0]      pe32_out,
    output logic [ACC_W-1:0]      pe33_out,
    output logic [N*ACC_W-1:0]    acc_out
);

    // Registered outputs of every PE, kept as 2-D arrays so they can be probed by row/column.
    data_t wt_out   [N][N];
    data_t data_out [N][N];
    acc_t  psum_out [N][N];

    genvar gr, gc;
    generate
        for (gr = 0; gr < N; gr++) begin : g_row
            for (gc = 0; gc < N; gc++) begin : g_col
                data_t wt_in;
                data_t dat_in;
                acc_t  ps_in;

                // Weights and partial sums flow down the columns; row 0 takes them from the ports.
                if (gr == 0) begin : g_top
                    assign wt_in = wt_arr[gc*DATA_W +: DATA_W];
                    assign ps_in = '0;
                end else begin : g_below
                    assign wt_in = wt_out[gr-1][gc];
                    assign ps_in = psum_out[gr-1][gc];
                end

                // Activations flow right along the rows; column 0 takes them from the ports.
                if (gc == 0) begin : g_left
                    assign dat_in = data_arr[gr*DATA_W +: DATA_W];
                end else begin : g_right
                    assign dat_in = data_out[gr][gc-1];
                end

                tpu_pe u_pe (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .control_i (control),
                    .wt_i      (wt_in),
                    .data_i    (dat_in),
                    .psum_i    (ps_in),
                    .wt_o      (wt_out[gr][gc]),
                    .data_o    (data_out[gr][gc]),
                    .psum_o    (psum_out[gr][gc])
                );
            end
        end
    endgenerate

    assign pe30_out = psum_out[N-1][0];
    assign pe31_out = psum_out[N-1][1];
    assign pe32_out = psum_out[N-1][2];
    assign pe33_out = psum_out[N-1][3];
    assign acc_out  = {pe33_out, pe32_out, pe31_out, pe30_out};

endmodule : tpu_mmu

// File: tb/tb_tpu_mmu.sv
module tb_tpu_mmu;
    import tpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         control;
    logic [31:0]  wt_arr;
    logic [31:0]  data_arr;
    logic [23:0]  pe30_out, pe31_out, pe32_out, pe33_out;
    logic [95:0]  acc_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   xs [4][4];   // xs[k][r]: vector k, byte r
    logic [23:0]  es [4][4];   // es[k][c]: expected pe3c_out for vector k
    logic [127:0] exp_diag;
    logic [127:0] exp_shift;

    tpu_mmu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .control  (control),
        .wt_arr   (wt_arr),
        .data_arr (data_arr),
        .pe30_out (pe30_out),
        .pe31_out (pe31_out),
        .pe32_out (pe32_out),
        .pe33_out (pe33_out),
        .acc_out  (acc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] wt_snap();
        logic [127:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[(r*4+c)*8 +: 8] = dut.wt_out[r][c];
        return v;
    endfunction

    function automatic logic [23:0] psum_or();
        logic [23:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v = v | dut.psum_out[r][c];
        return v;
    endfunction

    function automatic logic [23:0] pe_port(input int c);
        case (c)
            0:       return pe30_out;
            1:       return pe31_out;
            2:       return pe32_out;
            default: return pe33_out;
        endcase
    endfunction

    // Four load edges; the first word ends up in row 3.
    task automatic load_words(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] words [4];
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        control = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wt_arr = words[i];
            @(posedge clk); #1;
        end
        wt_arr = '0;
    endtask

    // Skewed stream of the 4 vectors in xs; compares every column slot against es.
    task automatic run_stream(input string tag);
        int k;
        control = 1'b0;
        for (int t = 0; t < 11; t++) begin
            for (int r = 0; r < 4; r++)
                data_arr[r*8 +: 8] = (t - r >= 0 && t - r < 4) ? xs[t-r][r] : 8'h00;
            @(posedge clk); #1;
            for (int c = 0; c < 4; c++) begin
                k = t - 3 - c;
                if (k >= 0 && k < 4) begin
                    chk($sformatf("%s pe3%0d k%0d", tag, c, k), {104'b0, pe_port(c)}, {104'b0, es[k][c]});
                    chk($sformatf("%s acc c%0d k%0d", tag, c, k), {104'b0, acc_out[c*24 +: 24]}, {104'b0, es[k][c]});
                end
            end
        end
        data_arr = '0;
    endtask

    task automatic set_identity_vectors();
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 4; r++) begin
                xs[k][r] = 8'(4*r + k);
                es[k][r] = 24'(4*r + k);
            end
    endtask

    initial begin
        exp_diag  = '0;
        exp_shift = '0;
        for (int r = 0; r < 4; r++) exp_diag[(r*5)*8] = 1'b1;
        for (int r = 1; r < 4; r++) exp_shift[(r*4 + r - 1)*8] = 1'b1;

        rst_n = 1'b0; control = 1'b1; wt_arr = '0; data_arr = '0;
        #1;
        chk("reset acc_out", {32'b0, acc_out}, 128'h0);
        chk("reset wt", wt_snap(), 128'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Identity weights and skewed identity stream.
        load_words(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
        chk("identity wt", wt_snap(), exp_diag);
        chk("load psum clear", {104'b0, psum_or()}, 128'h0);
        set_identity_vectors();
        run_stream("ident");

        // Weights hold across compute, then a single load edge shifts them one row.
        control = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data_arr = 32'h05_06_07_08;
            @(posedge clk); #1;
        end
        chk("hold wt", wt_snap(), exp_diag);
        control = 1'b1; wt_arr = '0; data_arr = '0;
        @(posedge clk); #1;
        chk("shift wt", wt_snap(), exp_shift);
        chk("shift psum", {104'b0, psum_or()}, 128'h0);
        chk("shift acc_out", {32'b0, acc_out}, 128'h0);

        // Full-scale weights and data.
        load_words(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 4; r++) begin
                xs[k][r] = 8'hFF;
                es[k][r] = 24'h03F804;
            end
        run_stream("full");

        // Asynchronous reset between edges during compute.
        load_words(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
        control = 1'b0;
        for (int t = 0; t < 5; t++) begin
            data_arr = 32'h0F_0A_05_03;
            @(posedge clk); #1;
        end
        chk("pre-reset acc busy", {127'b0, acc_out != 96'h0}, 128'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async acc_out", {32'b0, acc_out}, 128'h0);
        chk("async wt", wt_snap(), 128'h0);
        chk("async psum", {104'b0, psum_or()}, 128'h0);
        data_arr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        load_words(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
        chk("post-reset wt", wt_snap(), exp_diag);
        set_identity_vectors();
        run_stream("rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tpu_mmu

// File: doc/tpu_mmu.md
TPU_MMU -- requirements
Module: tpu_mmu

Interface
REQ-001 The block SHALL have no parameters; widths come from package constants N=4, DATA_W=8, ACC_W=24.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 control  input  1  1 = weight-load mode, 0 = compute mode.
REQ-005 wt_arr  input  32  byte c (bits 8c+7:8c) = weight entering top of column c.
REQ-006 data_arr  input  32  byte r (bits 8r+7:8r) = activation entering left of row r.
REQ-007 pe30_out, pe31_out, pe32_out, pe33_out  output  24 each  registered partial sum of bottom-row PE(3,c).
REQ-008 acc_out  output  96  = {pe33_out, pe32_out, pe31_out, pe30_out}.

Function
REQ-009 The block SHALL be a 4x4 weight-stationary systolic array of PEs indexed PE(r,c), r = row, c = column.
REQ-010 Each PE SHALL hold registers wt (8b), dat (8b), psum (24b).
REQ-011 Load, control=1: each edge, PE(0,c).wt <= wt_arr byte c and PE(r,c).wt <= PE(r-1,c).wt; after 4 edges, the byte loaded first sits in row 3.
REQ-012 Load, control=1: all dat and psum registers SHALL clear to 0.
REQ-013 Compute, control=0: wt registers SHALL hold.
REQ-014 Compute: PE(r,0) data input = data_arr byte r; PE(r,c>0) data input = PE(r,c-1).dat; each edge dat <= data input.
REQ-015 Compute: psum <= psum_in + data_input*wt; psum_in = 0 for row 0, else PE(r-1,c).psum.
REQ-016 Arithmetic SHALL be unsigned: 8x8 -> 16-bit product zero-extended; 24-bit add wraps modulo 2^24 (unreachable for 4 terms).
REQ-017 Skew contract: vector x of batch k drives byte r before edge k+r; pe3c_out = sum_r x_r*W[r][c] immediately after edge k+3+c.
REQ-018 The input skew SHALL be provided by the driver; the block adds no skew/deskew buffers.
REQ-019 A back-to-back vector stream SHALL yield one result per column per cycle with no bubbles.
REQ-020 Switching control 0->1 mid-stream SHALL discard in-flight sums; 1->0 starts compute on the next edge with the current weights.

Reset
REQ-021 On rst_n low, all wt, dat and psum registers SHALL clear to 0 immediately, independent of clk; all outputs read 0.
REQ-022 Reset deassertion SHALL take effect at the next rising edge; no other reset source exists.

Structure
REQ-023 Package tpu_pkg SHALL hold N, DATA_W, ACC_W and the PE array element typedefs.
REQ-024 One sub-module, tpu_pe (wt/dat/psum registers, MAC, load/compute mux), SHALL be instantiated 16 times with generate loops.
REQ-025 Internal nets SHALL be 2-D arrays wt_out[r][c], data_out[r][c], psum_out[r][c] so a bench can probe them hierarchically.

Verification
REQ-026 Identity load: control=1, wt_arr = 01000000, 00010000, 00000100, 00000001 on 4 edges -> wt diagonal = 01, all other wt = 00.
REQ-027 Identity compute: skewed streams byte0 00..03 from edge 0, byte1 04..07 from edge 1, byte2 08..0b from edge 2, byte3 0c..0f from edge 3 -> pe30 = 0,1,2,3 after edges 3..6 and pe33 = 12..15 after edges 6..9.
REQ-028 Full weights: all wt = FF, all data FF -> every pe3c_out = 4*65025 = 0x03F804 at its slot.
REQ-029 Weight hold: after loading, run 10 compute cycles -> wt_out unchanged; control=1 for one edge -> wt shifts one row and psum = 0.
REQ-030 Async reset: assert rst_n mid-compute between edges -> acc_out = 0 immediately; after release, a fresh identity run still matches REQ-027.
